// File: rtl/seq_divider.sv
// Restoring shift-and-subtract unsigned divider producing one quotient bit per clock,
// with a start/done handshake and a registered divide-by-zero flag.
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   a_shift;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   a_next;
  logic [WIDTH-1:0] q_next;

  // One restoring step: shift {A,Q} left, keep the subtraction only if it did not go negative.
  always_comb begin
    a_shift = (a_q << 1) | {{WIDTH{1'b0}}, q_q[WIDTH-1]};
    trial   = a_shift - {1'b0, m_q};
    if (trial[WIDTH]) begin
      a_next = a_shift;
      q_next = q_q << 1;
    end else begin
      a_next = trial;
      q_next = (q_q << 1) | {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor != '0) begin
            a_d     = '0;
            q_d     = dividend;
            m_d     = divisor;
            cnt_d   = CW'(WIDTH);
            state_d = RUN;
          end else begin
            quo_d   = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      RUN: begin
        a_d   = a_next;
        q_d   = q_next;
        cnt_d = cnt_q - CW'(1);
        // Results are loaded on the final step so they are valid as done rises.
        if (cnt_q == CW'(1)) begin
          quo_d   = q_next;
          rem_d   = a_next[WIDTH-1:0];
          dbz_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule
